// File: rtl/freq_result_calc_pkg.sv
// Shared definitions for the frequency meter result stage: default widths,
// reference rate and the FSM state encoding.
package freq_result_calc_pkg;

  // Reference tick rate in Hz (must stay below 2^32).
  localparam int unsigned DEF_REF_FREQ = 200_000_000;

  // Widths of the gate measurement and of the result.
  localparam int DEF_TICK_W = 32;
  localparam int DEF_EDGE_W = 16;
  localparam int DEF_OUT_W  = 32;

  // Dividend width; wide enough for EDGE_W + clog2(REF_FREQ) bits.
  localparam int DEF_NUM_W  = 48;

  // FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DIV   = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/freq_result_calc_udiv_serial.sv
// Serial restoring unsigned divider: one quotient bit per clock, MSB first.
// A start pulse loads the dividend/divisor and clears the partial remainder;
// the divider then runs for exactly NUM_W cycles. done_o is high during the
// final iteration, so quo_o/rem_o are final from the following cycle on and
// are held until the next start.
module udiv_serial #(
  parameter int NUM_W = 48,
  parameter int DEN_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [NUM_W-1:0] quo_o,
  output logic [DEN_W:0]   rem_o
);

  localparam int CNT_W = $clog2(NUM_W);

  logic [NUM_W-1:0] num_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W:0]   rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [DEN_W:0]   rem_sh;
  logic             ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q[DEN_W-1:0], num_q[cnt_q]};
    ge     = (rem_sh >= {1'b0, den_q});
    rem_d  = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
    quo_d  = {quo_q[NUM_W-2:0], ge};
  end

  // Operand load on start, then iterate while running.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      num_q <= num_i;
      den_q <= den_i;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= CNT_W'(NUM_W - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign done_o = run_q && (cnt_q == '0);
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/freq_result_calc.sv
// Result stage of the equal-precision frequency meter: converts a gate
// measurement (N edges over T reference ticks) into f = N*REF_FREQ/T Hz,
// rounded half-up and saturated, and presents it with a one-cycle valid.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for meas_valid; latches T and N on acceptance
// LOAD   | registers N*REF_FREQ into the divider; T==0 skips to DONE
// DIV    | divider iterating, NUM_W cycles
// ROUND  | half-up rounding and saturation; output registers loaded
// DONE   | freq_valid high for this one cycle; back to IDLE
module freq_result_calc
  import freq_result_calc_pkg::*;
#(
  parameter int unsigned REF_FREQ = DEF_REF_FREQ,
  parameter int          TICK_W   = DEF_TICK_W,
  parameter int          EDGE_W   = DEF_EDGE_W,
  parameter int          OUT_W    = DEF_OUT_W,
  parameter int          NUM_W    = DEF_NUM_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              meas_valid,
  input  logic [TICK_W-1:0] meas_ticks,
  input  logic [EDGE_W-1:0] meas_edges,
  output logic              busy,
  output logic              meas_drop,
  output logic              freq_valid,
  output logic [OUT_W-1:0]  freq_hz,
  output logic              freq_err
);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] ticks_q, ticks_d;
  logic [EDGE_W-1:0] edges_q, edges_d;
  logic              drop_q, drop_d;
  logic              fvalid_q, fvalid_d;
  logic [OUT_W-1:0]  fhz_q, fhz_d;
  logic              ferr_q, ferr_d;

  logic              div_start;
  logic              div_done;
  logic [NUM_W-1:0]  div_num;
  logic [NUM_W-1:0]  div_quo;
  logic [TICK_W:0]   div_rem;

  logic [TICK_W+1:0] rem_x2;
  logic              round_up;
  logic [NUM_W:0]    quo_rnd;
  logic              sat;

  // Constant multiply; the product is captured by the divider in LOAD.
  assign div_num = NUM_W'(edges_q) * NUM_W'(REF_FREQ);

  udiv_serial #(
    .NUM_W (NUM_W),
    .DEN_W (TICK_W)
  ) u_div (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (ticks_q),
    .done_o  (div_done),
    .quo_o   (div_quo),
    .rem_o   (div_rem)
  );

  // Half-up rounding and saturation on the finished quotient; a carry out of
  // OUT_W bits from the round-up saturates just like a plain overflow.
  always_comb begin
    rem_x2   = {div_rem, 1'b0};
    round_up = (rem_x2 >= {2'b00, ticks_q});
    quo_rnd  = {1'b0, div_quo} + {{NUM_W{1'b0}}, round_up};
    sat      = |quo_rnd[NUM_W:OUT_W];
  end

  // Next-state, operand latch and output register next values.
  always_comb begin
    state_d   = state_q;
    ticks_d   = ticks_q;
    edges_d   = edges_q;
    drop_d    = meas_valid && (state_q != ST_IDLE);
    fvalid_d  = 1'b0;
    fhz_d     = fhz_q;
    ferr_d    = ferr_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (meas_valid) begin
          ticks_d = meas_ticks;
          edges_d = meas_edges;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ticks_q == '0) begin
          fvalid_d = 1'b1;
          fhz_d    = '1;
          ferr_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        fvalid_d = 1'b1;
        fhz_d    = sat ? {OUT_W{1'b1}} : quo_rnd[OUT_W-1:0];
        ferr_d   = sat;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any computation in flight.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      ticks_q  <= '0;
      edges_q  <= '0;
      drop_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fhz_q    <= '0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ticks_q  <= ticks_d;
      edges_q  <= edges_d;
      drop_q   <= drop_d;
      fvalid_q <= fvalid_d;
      fhz_q    <= fhz_d;
      ferr_q   <= ferr_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign meas_drop  = drop_q;
  assign freq_valid = fvalid_q;
  assign freq_hz    = fhz_q;
  assign freq_err   = ferr_q;

endmodule
